load_ext_queue: RTL

LOAD_EXT_QUEUE -- requirements
Module: load_ext_queue

---
 rtl/load_ext_queue_if.sv | 27 ++
 rtl/load_ext_queue.sv | 117 +++++++++++
 2 files changed

// File: rtl/load_ext_queue_if.sv
// Load-response and result handshake bundle for load_ext_queue.
// The slave modport is the queue; the master modport is the producer/consumer side.
interface load_ext_queue_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_word;
    logic [1:0]       in_addr;
    logic [2:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport slave (
        input  in_valid, in_word, in_addr, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

    modport master (
        output in_valid, in_word, in_addr, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/load_ext_queue.sv
// Load-result extension unit with an in-order result buffer of DEPTH entries.
// Optional macro LOAD_EXT_QUEUE_MISALIGN_CHK_EN flags misaligned LH/LHU/LW as errors.
module load_ext_queue #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    load_ext_queue_if.slave  bus
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 1 + TAG_W + 32;

    localparam logic [2:0] MODE_LB  = 3'b000;
    localparam logic [2:0] MODE_LBU = 3'b001;
    localparam logic [2:0] MODE_LH  = 3'b010;
    localparam logic [2:0] MODE_LHU = 3'b011;
    localparam logic [2:0] MODE_LW  = 3'b100;

    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic        push;
    logic        pop;
    logic        not_empty;
    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;
    logic        ext_err;
    logic        misaligned;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = bus.in_word[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = byte_lane[bus.in_addr];
    assign half_sel = bus.in_addr[1] ? bus.in_word[31:16] : bus.in_word[15:0];

`ifdef LOAD_EXT_QUEUE_MISALIGN_CHK_EN
    assign misaligned = (((bus.in_mode == MODE_LH) || (bus.in_mode == MODE_LHU)) && bus.in_addr[0])
                      || ((bus.in_mode == MODE_LW) && (bus.in_addr != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        ext_data = 32'd0;
        ext_err  = 1'b0;
        case (bus.in_mode)
            MODE_LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            MODE_LBU: ext_data = {24'd0, byte_sel};
            MODE_LH:  ext_data = {{16{half_sel[15]}}, half_sel};
            MODE_LHU: ext_data = {16'd0, half_sel};
            MODE_LW:  ext_data = bus.in_word;
            default:  ext_err  = 1'b1;
        endcase
        if (misaligned) begin
            ext_data = 32'd0;
            ext_err  = 1'b1;
        end
    end

    // A full buffer blocks input even when the head is popping this cycle.
    assign not_empty    = (count_reg != '0);
    assign bus.in_ready = (count_reg < CNT_W'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready && !flush;
    assign pop          = not_empty && bus.out_ready && !flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is not reset; the output mask below hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= {ext_err, bus.in_tag, ext_data};
    end

    assign bus.out_valid = not_empty;
    assign bus.out_err   = not_empty ? mem[rd_ptr_reg][ENTRY_W-1]      : 1'b0;
    assign bus.out_tag   = not_empty ? mem[rd_ptr_reg][32 +: TAG_W]    : '0;
    assign bus.out_data  = not_empty ? mem[rd_ptr_reg][31:0]           : 32'd0;
endmodule
